wb_rr_arbiter: RTL and testbench

Wishbone round-robin arbiter that shares one slave port among `MASTER_COUNT` masters. It sits between several bus masters (CPU instruction/data ports, DMA) and a single shared slave or crossbar input. It grants bus ownership for a whole `cyc` period with rotating priority. A per-transfer watchdog aborts a stalled slave by returning `err` to the owning master.

---
 rtl/wb_rr_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
//
// Wishbone round-robin arbiter sharing one slave port among MASTER_COUNT
// masters. A master owns the bus for its whole cyc period. Priority rotates
// to the master after the last owner. A per-transfer watchdog aborts a
// stalled slave by returning a single-cycle err to the owner. The owner is
// then held off the slave until it drops cyc.
//
// Ports:
//   sys_clk, sys_rst       clock, synchronous active-high reset
//   master_cyc/stb/we      per-master Wishbone controls
//   master_tag/sel/adr     per-master cycle tag, byte selects, address
//   master_mosi            per-master write data
//   master_miso            per-master read data (owner only, else 0)
//   master_ack/err         per-master terminations (owner only, else 0)
//   slave_cyc/stb/we/tag/sel/adr/mosi   request mux toward the shared slave
//   slave_miso/ack/err     response from the shared slave
//   grant                  one-hot current owner (0 while idle)
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MASTER_COUNT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                                     sys_clk,
    input  logic                                     sys_rst,
    input  logic [MASTER_COUNT-1:0]                  master_cyc,
    input  logic [MASTER_COUNT-1:0]                  master_stb,
    input  logic [MASTER_COUNT-1:0]                  master_we,
    input  logic [MASTER_COUNT-1:0][2:0]             master_tag,
    input  logic [MASTER_COUNT-1:0][DATA_WIDTH/8-1:0] master_sel,
    input  logic [MASTER_COUNT-1:0][ADDR_WIDTH-1:0]  master_adr,
    input  logic [MASTER_COUNT-1:0][DATA_WIDTH-1:0]  master_mosi,
    output logic [MASTER_COUNT-1:0][DATA_WIDTH-1:0]  master_miso,
    output logic [MASTER_COUNT-1:0]                  master_ack,
    output logic [MASTER_COUNT-1:0]                  master_err,
    output logic                                     slave_cyc,
    output logic                                     slave_stb,
    output logic                                     slave_we,
    output logic [2:0]                               slave_tag,
    output logic [DATA_WIDTH/8-1:0]                  slave_sel,
    output logic [ADDR_WIDTH-1:0]                    slave_adr,
    output logic [DATA_WIDTH-1:0]                    slave_mosi,
    input  logic [DATA_WIDTH-1:0]                    slave_miso,
    input  logic                                     slave_ack,
    input  logic                                     slave_err,
    output logic [MASTER_COUNT-1:0]                  grant
);

    localparam int OWNER_WIDTH = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
    localparam int WDOG_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WDOG_ENABLE = (TIMEOUT != 0);
    localparam logic [WDOG_WIDTH-1:0]  WDOG_LAST = WDOG_WIDTH'(TIMEOUT - 1);
    localparam logic [OWNER_WIDTH-1:0] OWNER_MAX = OWNER_WIDTH'(MASTER_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_ABORT = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                   state_r;
    logic [OWNER_WIDTH-1:0]   owner_r;
    logic [OWNER_WIDTH-1:0]   ptr_r;
    logic [WDOG_WIDTH-1:0]    wdog_r;
    logic [MASTER_COUNT-1:0]  grant_r;

    logic [OWNER_WIDTH-1:0]   scan_s;
    logic [OWNER_WIDTH-1:0]   pick_idx_s;
    logic                     pick_valid_s;
    logic [OWNER_WIDTH-1:0]   next_ptr_s;
    logic                     stall_s;
    logic                     abort_now_s;

    // Increment modulo MASTER_COUNT; explicit wrap keeps non-power-of-two counts correct.
    function automatic logic [OWNER_WIDTH-1:0] wrap_inc(input logic [OWNER_WIDTH-1:0] idx);
        logic [OWNER_WIDTH-1:0] res;
        if (idx == OWNER_MAX) begin
            res = '0;
        end else begin
            res = idx + OWNER_WIDTH'(1);
        end
        return res;
    endfunction

    function automatic logic [MASTER_COUNT-1:0] owner_onehot(input logic [OWNER_WIDTH-1:0] idx);
        logic [MASTER_COUNT-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Rotating-priority search: first requester at ptr, ptr+1, ... wrapping.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        scan_s       = ptr_r;
        for (int i = 0; i < MASTER_COUNT; i++) begin
            if (!pick_valid_s && master_cyc[scan_s]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = scan_s;
            end else begin
                pick_valid_s = pick_valid_s;
            end
            scan_s = wrap_inc(scan_s);
        end
    end

    // Next priority pointer and watchdog stall / abort qualification.
    always_comb begin
        next_ptr_s  = wrap_inc(owner_r);
        stall_s     = (state_r == ST_OWN) && master_stb[owner_r] && !slave_ack && !slave_err;
        abort_now_s = WDOG_ENABLE && stall_s && (wdog_r == WDOG_LAST);
    end

    // Arbitration FSM with owner, rotation pointer, watchdog and grant registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
            owner_r <= '0;
            ptr_r   <= '0;
            wdog_r  <= '0;
            grant_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wdog_r <= '0;
                    if (pick_valid_s) begin
                        state_r <= ST_OWN;
                        owner_r <= pick_idx_s;
                        grant_r <= owner_onehot(pick_idx_s);
                    end
                end
                ST_OWN: begin
                    // Release has priority over an abort on the threshold cycle.
                    if (!master_cyc[owner_r]) begin
                        state_r <= ST_IDLE;
                        ptr_r   <= next_ptr_s;
                        wdog_r  <= '0;
                        grant_r <= '0;
                    end else if (abort_now_s) begin
                        state_r <= ST_ABORT;
                        wdog_r  <= '0;
                    end else if (WDOG_ENABLE && stall_s) begin
                        wdog_r  <= wdog_r + WDOG_WIDTH'(1);
                    end else begin
                        wdog_r  <= '0;
                    end
                end
                ST_ABORT: begin
                    state_r <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!master_cyc[owner_r]) begin
                        state_r <= ST_IDLE;
                        ptr_r   <= next_ptr_s;
                        grant_r <= '0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                    wdog_r  <= '0;
                end
            endcase
        end
    end

    // Request mux toward the slave and response demux toward the owner.
    always_comb begin
        slave_cyc   = 1'b0;
        slave_stb   = 1'b0;
        slave_we    = 1'b0;
        slave_tag   = 3'b000;
        slave_sel   = '0;
        slave_adr   = '0;
        slave_mosi  = '0;
        master_miso = '0;
        master_ack  = '0;
        master_err  = '0;
        case (state_r)
            ST_OWN: begin
                slave_cyc            = master_cyc[owner_r];
                slave_stb            = master_stb[owner_r];
                slave_we             = master_we[owner_r];
                slave_tag            = master_tag[owner_r];
                slave_sel            = master_sel[owner_r];
                slave_adr            = master_adr[owner_r];
                slave_mosi           = master_mosi[owner_r];
                master_miso[owner_r] = slave_miso;
                master_ack[owner_r]  = slave_ack;
                master_err[owner_r]  = slave_err;
            end
            ST_ABORT: begin
                master_err[owner_r] = 1'b1;
            end
            ST_IDLE: begin
                master_err = '0;
            end
            ST_DRAIN: begin
                master_err = '0;
            end
            default: begin
                master_err = '0;
            end
        endcase
    end

    assign grant = grant_r;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [3:0]        master_cyc, master_stb, master_we;
    logic [3:0][2:0]   master_tag;
    logic [3:0][3:0]   master_sel;
    logic [3:0][31:0]  master_adr, master_mosi, master_miso;
    logic [3:0]        master_ack, master_err;
    logic              slave_cyc, slave_stb, slave_we;
    logic [2:0]        slave_tag;
    logic [3:0]        slave_sel;
    logic [31:0]       slave_adr, slave_mosi, slave_miso;
    logic              slave_ack, slave_err;
    logic [3:0]        grant;

    int checks = 0;
    int errors = 0;

    wb_rr_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MASTER_COUNT(4), .TIMEOUT(8)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .master_cyc(master_cyc), .master_stb(master_stb), .master_we(master_we),
        .master_tag(master_tag), .master_sel(master_sel), .master_adr(master_adr),
        .master_mosi(master_mosi), .master_miso(master_miso),
        .master_ack(master_ack), .master_err(master_err),
        .slave_cyc(slave_cyc), .slave_stb(slave_stb), .slave_we(slave_we),
        .slave_tag(slave_tag), .slave_sel(slave_sel), .slave_adr(slave_adr),
        .slave_mosi(slave_mosi), .slave_miso(slave_miso),
        .slave_ack(slave_ack), .slave_err(slave_err), .grant(grant)
    );

    always #5 sys_clk = ~sys_clk;

    // Fixed per-master request attributes, distinct for every master.
    function automatic logic [31:0] adr_of(input int i);
        return {16'h0000, 4'(i), 12'h100};
    endfunction
    function automatic logic [31:0] mosi_of(input int i);
        return {28'hA5A5A5A, 4'(i)};
    endfunction
    function automatic logic [3:0] sel_of(input int i);
        return 4'(4'hF >> i);
    endfunction
    function automatic logic [2:0] tag_of(input int i);
        return 3'(i + 1);
    endfunction
    function automatic logic we_of(input int i);
        return 1'(i % 2);
    endfunction

    typedef struct packed {
        logic        rst;
        logic [3:0]  cyc;
        logic [3:0]  stb;
        logic        ack;
        logic        err;
        logic [31:0] miso;
        logic [3:0]  e_grant;
        logic        e_scyc;
        logic        e_sstb;
        logic [3:0]  e_ack;
        logic [3:0]  e_err;
        logic        e_own;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] cyc, input logic [3:0] stb,
                                input logic ack, input logic err, input logic [31:0] miso,
                                input logic [3:0] g, input logic sc, input logic ss,
                                input logic [3:0] ma, input logic [3:0] me, input logic own);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err; v.miso = miso;
        v.e_grant = g; v.e_scyc = sc; v.e_sstb = ss; v.e_ack = ma; v.e_err = me; v.e_own = own;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step_chk(input string name, input logic [3:0] g, input logic sc,
                            input logic [3:0] ma, input logic [3:0] me);
        @(negedge sys_clk);
        check(name, 128'({grant, slave_cyc, master_ack, master_err}), 128'({g, sc, ma, me}));
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1; master_cyc = 4'b0000; master_stb = 4'b0000;
        slave_ack = 1'b0; slave_err = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    initial begin
        vec_t v;
        int idx;
        logic [3:0][31:0] exp_miso;
        logic [71:0] exp_path;
        logic [31:0] miso_drv;

        for (int i = 0; i < 4; i++) begin
            master_adr[i] = adr_of(i); master_mosi[i] = mosi_of(i);
            master_sel[i] = sel_of(i); master_tag[i] = tag_of(i); master_we[i] = we_of(i);
        end
        sys_rst = 1'b1; master_cyc = 4'b0000; master_stb = 4'b0000;
        slave_ack = 1'b0; slave_err = 1'b0; slave_miso = 32'h0000_0000;
        repeat (2) @(posedge sys_clk);
        #1;

        // Reset state and single M0 read acked on the 2nd strobed cycle
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, 32'h0, 4'b0001, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 32'hDEADBEEF, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));
        // Round robin with all four masters requesting: 0,1,2,3,0,1
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0, 32'h0, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0010, 1'b1, 1'b0, 32'h0, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b1101, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0100, 1'b1, 1'b0, 32'h0, 4'b0100, 1'b1, 1'b1, 4'b0100, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b1011, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b1000, 1'b1, 1'b0, 32'h0, 4'b1000, 1'b1, 1'b1, 4'b1000, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b0111, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b1000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0, 32'h0, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0010, 1'b1, 1'b0, 32'h0, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));
        // Priority rotation: M2 beats M3 from reset, then M3 beats M1; idle ignores slave ack/err
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1100, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1100, 4'b0100, 1'b0, 1'b0, 32'h0, 4'b0100, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b1010, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b1010, 4'b0000, 1'b1, 1'b1, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1010, 4'b1000, 1'b1, 1'b0, 32'h0, 4'b1000, 1'b1, 1'b1, 4'b1000, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b1000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0010, 4'b0010, 1'b0, 1'b1, 32'h0, 4'b0010, 1'b1, 1'b1, 4'b0000, 4'b0010, 1'b1));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            miso_drv = (v.miso != 32'h0) ? v.miso : (32'hC0DE_0000 | 32'(k));
            sys_rst = v.rst; master_cyc = v.cyc; master_stb = v.stb;
            slave_ack = v.ack; slave_err = v.err; slave_miso = miso_drv;
            idx = 0;
            for (int i = 0; i < 4; i++) begin
                if (v.e_grant[i]) idx = i;
            end
            exp_miso = '0;
            exp_path = '0;
            if (v.e_own) begin
                exp_path = {we_of(idx), tag_of(idx), sel_of(idx), adr_of(idx), mosi_of(idx)};
                exp_miso[idx] = miso_drv;
            end
            @(negedge sys_clk);
            check($sformatf("vec%0d_ctl", k),
                  128'({grant, slave_cyc, slave_stb, master_ack, master_err}),
                  128'({v.e_grant, v.e_scyc, v.e_sstb, v.e_ack, v.e_err}));
            check($sformatf("vec%0d_req", k),
                  128'({slave_we, slave_tag, slave_sel, slave_adr, slave_mosi}), 128'(exp_path));
            check($sformatf("vec%0d_miso", k), 128'(master_miso), 128'(exp_miso));
            @(posedge sys_clk);
            #1;
        end

        // Watchdog: M1 strobes, slave never responds
        do_reset();
        slave_miso = 32'h1234_5678;
        master_cyc = 4'b0010; master_stb = 4'b0010;
        step_chk("wd_req", 4'b0000, 1'b0, 4'b0000, 4'b0000);
        for (int c = 0; c < 8; c++) step_chk($sformatf("wd_stall%0d", c), 4'b0010, 1'b1, 4'b0000, 4'b0000);
        @(negedge sys_clk);
        check("wd_abort", 128'({grant, slave_cyc, master_ack, master_err}), 128'({4'b0010, 1'b0, 4'b0000, 4'b0010}));
        check("wd_abort_gate", 128'({slave_stb, master_miso}), 128'(0));
        @(posedge sys_clk);
        #1;
        slave_ack = 1'b1;
        for (int c = 0; c < 3; c++) step_chk($sformatf("wd_drain%0d", c), 4'b0010, 1'b0, 4'b0000, 4'b0000);
        slave_ack = 1'b0; master_cyc = 4'b0000; master_stb = 4'b0000;
        step_chk("wd_release", 4'b0010, 1'b0, 4'b0000, 4'b0000);
        step_chk("wd_idle", 4'b0000, 1'b0, 4'b0000, 4'b0000);

        // Threshold race: ack on the 8th stalled cycle, fresh budget, then cyc drop on threshold
        do_reset();
        master_cyc = 4'b0001; master_stb = 4'b0001;
        step_chk("race_req", 4'b0000, 1'b0, 4'b0000, 4'b0000);
        for (int c = 0; c < 7; c++) step_chk($sformatf("race_a%0d", c), 4'b0001, 1'b1, 4'b0000, 4'b0000);
        slave_ack = 1'b1;
        step_chk("race_ack_a", 4'b0001, 1'b1, 4'b0001, 4'b0000);
        slave_ack = 1'b0;
        for (int c = 0; c < 7; c++) step_chk($sformatf("race_b%0d", c), 4'b0001, 1'b1, 4'b0000, 4'b0000);
        slave_ack = 1'b1;
        step_chk("race_ack_b", 4'b0001, 1'b1, 4'b0001, 4'b0000);
        slave_ack = 1'b0;
        for (int c = 0; c < 7; c++) step_chk($sformatf("race_c%0d", c), 4'b0001, 1'b1, 4'b0000, 4'b0000);
        master_cyc = 4'b0000;
        step_chk("race_drop", 4'b0001, 1'b0, 4'b0000, 4'b0000);
        master_stb = 4'b0000;
        step_chk("race_idle", 4'b0000, 1'b0, 4'b0000, 4'b0000);

        // Reset while M3 owns the bus with stb high
        do_reset();
        slave_miso = 32'h7777_0003;
        master_cyc = 4'b1000; master_stb = 4'b1000;
        step_chk("rst_req", 4'b0000, 1'b0, 4'b0000, 4'b0000);
        step_chk("rst_own", 4'b1000, 1'b1, 4'b0000, 4'b0000);
        sys_rst = 1'b1; master_cyc = 4'b1001; master_stb = 4'b1001;
        step_chk("rst_edge", 4'b1000, 1'b1, 4'b0000, 4'b0000);
        sys_rst = 1'b0; slave_ack = 1'b1;
        @(negedge sys_clk);
        check("rst_outputs", 128'({grant, slave_cyc, slave_stb, slave_we, slave_tag, slave_sel,
                                   slave_adr, slave_mosi, master_ack, master_err}), 128'(0));
        check("rst_miso", 128'(master_miso), 128'(0));
        @(posedge sys_clk);
        #1;
        slave_ack = 1'b0;
        @(negedge sys_clk);
        check("rst_rearb", 128'({grant, slave_cyc, slave_adr}), 128'({4'b0001, 1'b1, 32'h0000_0100}));
        @(posedge sys_clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
